// File: rtl/rptr_empty_if.sv
// Read-side FIFO pointer bundle: consumer request, synchronized write pointer and read status.
// Ports: rinc, rq2_wptr, rerr_clr from the consumer; raddr, rptr, rempty, raempty, rfill,
// runderflow back from the read-pointer block. master = consumer, slave = rptr_empty.
interface rptr_empty_if #(
  parameter int ADDRSIZE = 4
);
  logic                rinc;
  logic [ADDRSIZE:0]   rq2_wptr;
  logic                rerr_clr;
  logic [ADDRSIZE-1:0] raddr;
  logic [ADDRSIZE:0]   rptr;
  logic                rempty;
  logic                raempty;
  logic [ADDRSIZE:0]   rfill;
  logic                runderflow;

  modport master (
    output rinc, rq2_wptr, rerr_clr,
    input  raddr, rptr, rempty, raempty, rfill, runderflow
  );

  modport slave (
    input  rinc, rq2_wptr, rerr_clr,
    output raddr, rptr, rempty, raempty, rfill, runderflow
  );
endinterface

// File: rtl/rptr_empty.sv
// Async FIFO read pointer and empty/almost-empty/fill/underflow flag generation.
// Latency: all flags registered, updated one rclk after rinc or rq2_wptr changes.
// Backpressure: rinc is ignored while rempty is set; such attempts set sticky runderflow.
// Ports: rclk, rrst (sync active-high), rd (rptr_empty_if.slave bundle).
module rptr_empty #(
  parameter int ADDRSIZE      = 4,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic         rclk,
  input  logic         rrst,
  rptr_empty_if.slave  rd
);

  localparam logic [ADDRSIZE:0] THRESH = AEMPTY_THRESH[ADDRSIZE:0];

  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] rbinnext;
  logic [ADDRSIZE:0] rgraynext;
  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] fill_next;
  logic              rd_en;

  // A read only advances the pointer when there is data to consume.
  assign rd_en     = rd.rinc & ~rd.rempty;
  assign rbinnext  = rbin + {{ADDRSIZE{1'b0}}, rd_en};
  assign rgraynext = (rbinnext >> 1) ^ rbinnext;
  assign rd.raddr  = rbin[ADDRSIZE-1:0];

  // Gray to binary: each bit is the XOR of itself and all higher Gray bits.
  always_comb begin
    wbin = rd.rq2_wptr;
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      wbin[i] = wbin[i+1] ^ rd.rq2_wptr[i];
    end
  end

  // Occupancy after this cycle's read; the extra MSB makes full (2^ADDRSIZE) distinct from 0.
  assign fill_next = wbin - rbinnext;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin          <= '0;
      rd.rptr       <= '0;
      rd.rempty     <= 1'b1;
      rd.raempty    <= 1'b1;
      rd.rfill      <= '0;
      rd.runderflow <= 1'b0;
    end else begin
      rbin       <= rbinnext;
      rd.rptr    <= rgraynext;
      // Compare against next pointer so empty rises on the edge that takes the last entry.
      rd.rempty  <= (rgraynext == rd.rq2_wptr);
      rd.raempty <= (fill_next <= THRESH);
      rd.rfill   <= fill_next;
      // Set wins over clear when both happen together.
      if (rd.rinc && rd.rempty) begin
        rd.runderflow <= 1'b1;
      end else if (rd.rerr_clr) begin
        rd.runderflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rptr_empty.sv
module tb_rptr_empty;

  localparam int AW     = 4;
  localparam int DEPTH  = 16;
  localparam int PMOD   = 32;
  localparam int THRESH = 2;

  logic rclk;
  logic rrst;

  rptr_empty_if #(.ADDRSIZE(AW)) rd ();

  rptr_empty #(.ADDRSIZE(AW), .AEMPTY_THRESH(THRESH)) dut (
    .rclk (rclk),
    .rrst (rrst),
    .rd   (rd)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  int n_vec  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Write count as a plain integer; the bench drives its Gray code onto rq2_wptr.
  int w_cnt = 0;

  // Behavioural model: reads consumed so far (mod 32) and the resulting registered flags.
  int m_r     = 0;
  bit m_empty = 1'b1;
  bit m_aempty = 1'b1;
  int m_fill  = 0;
  bit m_uf    = 1'b0;

  function automatic int gray(input int v);
    return v ^ (v >> 1);
  endfunction

  function automatic int occ(input int w, input int r);
    return ((w - r) % PMOD + PMOD) % PMOD;
  endfunction

  function automatic int next_r(input int r, input bit inc, input bit emp);
    return (r + ((inc && !emp) ? 1 : 0)) % PMOD;
  endfunction

  task automatic cmp(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  always @(posedge rclk) begin
    if (rrst) begin
      m_r      <= 0;
      m_empty  <= 1'b1;
      m_aempty <= 1'b1;
      m_fill   <= 0;
      m_uf     <= 1'b0;
    end else begin
      m_r      <= next_r(m_r, rd.rinc, m_empty);
      m_fill   <= occ(w_cnt, next_r(m_r, rd.rinc, m_empty));
      m_empty  <= occ(w_cnt, next_r(m_r, rd.rinc, m_empty)) == 0;
      m_aempty <= occ(w_cnt, next_r(m_r, rd.rinc, m_empty)) <= THRESH;
      if (rd.rinc && m_empty) m_uf <= 1'b1;
      else if (rd.rerr_clr)   m_uf <= 1'b0;
    end
  end

  // Compare process: every cycle, on the falling edge.
  always @(negedge rclk) begin
    if (chk_en) begin
      cmp("m_raddr",  int'(rd.raddr),      m_r % DEPTH);
      cmp("m_rptr",   int'(rd.rptr),       gray(m_r));
      cmp("m_rempty", int'(rd.rempty),     int'(m_empty));
      cmp("m_raempty", int'(rd.raempty),   int'(m_aempty));
      cmp("m_rfill",  int'(rd.rfill),      m_fill);
      cmp("m_uflow",  int'(rd.runderflow), int'(m_uf));
    end
  end

  task automatic drive(input bit rst, input bit inc, input bit clr, input int w);
    rrst        = rst;
    rd.rinc     = inc;
    rd.rerr_clr = clr;
    w_cnt       = w % PMOD;
    rd.rq2_wptr = 5'(gray(w_cnt));
  endtask

  task automatic step();
    @(posedge rclk);
    @(negedge rclk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    cmp({tag, "_rptr"},   int'(rd.rptr), 0);
    cmp({tag, "_raddr"},  int'(rd.raddr), 0);
    cmp({tag, "_rempty"}, int'(rd.rempty), 1);
    cmp({tag, "_raempty"}, int'(rd.raempty), 1);
    cmp({tag, "_rfill"},  int'(rd.rfill), 0);
    cmp({tag, "_uflow"},  int'(rd.runderflow), 0);
  endtask

  initial begin
    drive(1'b1, 1'b1, 1'b0, 3);
    step();
    chk_en = 1'b1;

    // Reset held two edges with a pending read and 3 entries visible.
    step();
    chk_reset_vals("rst");
    drive(1'b0, 1'b0, 1'b0, 3);
    step();
    cmp("rel_rempty", int'(rd.rempty), 0);
    cmp("rel_rfill",  int'(rd.rfill), 3);
    cmp("rel_raempty", int'(rd.raempty), 0);

    // Drain 3 entries.
    cmp("drain_raddr0", int'(rd.raddr), 0);
    drive(1'b0, 1'b1, 1'b0, 3);
    step();
    cmp("drain_raddr1", int'(rd.raddr), 1);
    cmp("drain_fill2",  int'(rd.rfill), 2);
    cmp("drain_aempty", int'(rd.raempty), 1);
    step();
    cmp("drain_raddr2", int'(rd.raddr), 2);
    cmp("drain_empty_early", int'(rd.rempty), 0);
    step();
    cmp("drain_rptr",   int'(rd.rptr), 5'b00010);
    cmp("drain_rempty", int'(rd.rempty), 1);
    cmp("drain_rfill",  int'(rd.rfill), 0);

    // Underflow: set, hold, clear, and set-beats-clear.
    step();
    cmp("uf_rptr", int'(rd.rptr), 5'b00010);
    cmp("uf_set",  int'(rd.runderflow), 1);
    drive(1'b0, 1'b0, 1'b0, 3);
    step();
    cmp("uf_hold", int'(rd.runderflow), 1);
    drive(1'b0, 1'b0, 1'b1, 3);
    step();
    cmp("uf_clr", int'(rd.runderflow), 0);
    drive(1'b0, 1'b1, 1'b1, 3);
    step();
    cmp("uf_prio", int'(rd.runderflow), 1);

    // Full occupancy from rbin=0 then 16 reads.
    drive(1'b1, 1'b0, 1'b0, 0);
    step();
    drive(1'b0, 1'b0, 1'b0, 16);
    step();
    cmp("full_rfill",  int'(rd.rfill), 16);
    cmp("full_rempty", int'(rd.rempty), 0);
    cmp("full_raempty", int'(rd.raempty), 0);
    drive(1'b0, 1'b1, 1'b0, 16);
    for (int i = 1; i <= 16; i++) begin
      step();
      cmp($sformatf("full_empty_rd%0d", i), int'(rd.rempty), (i == 16) ? 1 : 0);
    end
    cmp("full_rptr", int'(rd.rptr), 5'b11000);

    // Wrap of rbin from 15 through 16.
    drive(1'b1, 1'b0, 1'b0, 0);
    step();
    drive(1'b0, 1'b0, 1'b0, 15);
    step();
    drive(1'b0, 1'b1, 1'b0, 15);
    repeat (15) step();
    cmp("wrap_pre_raddr", int'(rd.raddr), 15);
    drive(1'b0, 1'b0, 1'b0, 17);
    step();
    cmp("wrap_pre_fill", int'(rd.rfill), 2);
    drive(1'b0, 1'b1, 1'b0, 17);
    step();
    cmp("wrap_raddr",  int'(rd.raddr), 0);
    cmp("wrap_rptr",   int'(rd.rptr), 5'b11000);
    cmp("wrap_rfill",  int'(rd.rfill), 1);
    cmp("wrap_rempty", int'(rd.rempty), 0);

    // Reset in the middle of a drain.
    drive(1'b1, 1'b0, 1'b0, 0);
    step();
    drive(1'b0, 1'b0, 1'b0, 8);
    step();
    drive(1'b0, 1'b1, 1'b0, 8);
    repeat (3) step();
    cmp("mid_fill5", int'(rd.rfill), 5);
    drive(1'b1, 1'b1, 1'b0, 8);
    step();
    chk_reset_vals("mid");
    drive(1'b0, 1'b0, 1'b0, 0);
    step();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      int  w;
      bit  inc;
      bit  clr;
      bit  rst;
      inc = ($urandom_range(0, 99) < 55);
      clr = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 299) == 0);
      w   = w_cnt;
      if (rst) begin
        w = 0;
      end else if (occ(w_cnt, m_r) < DEPTH && $urandom_range(0, 99) < 50) begin
        w = w_cnt + 1;
      end
      drive(rst, inc, clr, w);
      step();
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/rptr_empty.md
RPTR_EMPTY -- requirements
Module: rptr_empty

Interface
REQ-001 SHALL have parameter ADDRSIZE, default 4, meaning FIFO address width (depth 2^ADDRSIZE).
REQ-002 SHALL have parameter AEMPTY_THRESH, default 2, meaning almost-empty threshold in entries, range 0..2^ADDRSIZE-1.
REQ-003 SHALL have port rclk, input, 1, read-domain clock; all state updates on rising edge.
REQ-004 SHALL have port rrst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port rinc, input, 1, read request from consumer.
REQ-006 SHALL have port rq2_wptr, input, ADDRSIZE+1, Gray write pointer already synchronized into rclk domain.
REQ-007 SHALL have port rerr_clr, input, 1, clears sticky underflow flag.
REQ-008 SHALL have port raddr, output, ADDRSIZE, binary read address to FIFO memory.
REQ-009 SHALL have port rptr, output, ADDRSIZE+1, registered Gray read pointer for crossing to write domain.
REQ-010 SHALL have port rempty, output, 1, registered empty flag.
REQ-011 SHALL have port raempty, output, 1, registered almost-empty flag.
REQ-012 SHALL have port rfill, output, ADDRSIZE+1, registered occupancy as seen by read domain, 0..2^ADDRSIZE.
REQ-013 SHALL have port runderflow, output, 1, sticky flag for read attempted while empty.

Function
REQ-014 SHALL hold an ADDRSIZE+1-bit binary read counter rbin; raddr SHALL equal rbin[ADDRSIZE-1:0] combinationally.
REQ-015 SHALL compute rbinnext = rbin + (rinc AND NOT rempty), modulo 2^(ADDRSIZE+1).
REQ-016 SHALL compute rgraynext = (rbinnext >> 1) XOR rbinnext; rbin <= rbinnext and rptr <= rgraynext each cycle.
REQ-017 SHALL only ever change rptr by one Gray bit per cycle (at most one increment per clock).
REQ-018 SHALL register rempty <= (rgraynext == rq2_wptr); rempty therefore asserts on the same edge that consumes the last entry, with no bubble cycle.
REQ-019 SHALL convert rq2_wptr to binary wbin (bit i = XOR of bits ADDRSIZE..i) combinationally.
REQ-020 SHALL register rfill <= wbin - rbinnext, modulo 2^(ADDRSIZE+1); rfill==0 SHALL coincide with rempty==1.
REQ-021 SHALL register raempty <= ((wbin - rbinnext) <= AEMPTY_THRESH).
REQ-022 SHALL ignore rinc while rempty==1: rbin, rptr, raddr hold.
REQ-023 SHALL set runderflow on the edge after any cycle with rinc==1 and rempty==1; SHALL hold it until rerr_clr==1 or reset.
REQ-024 SHALL give set priority over rerr_clr when both occur in the same cycle.
REQ-025 SHALL wrap rbin from 2^(ADDRSIZE+1)-1 to 0 with no special handling; wrap of the low ADDRSIZE bits SHALL toggle the pointer MSB, distinguishing full from empty.
REQ-026 SHALL update all outputs from rq2_wptr one rclk after it changes, adding no further synchronization.

Reset
REQ-027 SHALL, while rrst==1 at a rising edge, force rbin=0, rptr=0, raddr=0, rempty=1, raempty=1, rfill=0, runderflow=0, regardless of rinc, rerr_clr, rq2_wptr.
REQ-028 SHALL discard any in-progress read on reset mid-operation; the first post-reset edge SHALL evaluate REQ-018..021 from rbin=0.

Verification
REQ-029 SHALL verify reset: rrst=1 two cycles with rinc=1, rq2_wptr=5'b00010 -> rptr=0, raddr=0, rempty=1, raempty=1, rfill=0, runderflow=0; next edge after release -> rempty=0, rfill=3, raempty=0.
REQ-030 SHALL verify drain: rq2_wptr=5'b00010 (3 entries), rinc=1 three cycles -> raddr 0,1,2; after 3rd edge rptr=5'b00010, rempty=1, rfill=0; raempty=1 after 1st read (fill 2).
REQ-031 SHALL verify wrap: rbin=15, rq2_wptr=gray(17)=5'b11001, one read -> raddr=0, rptr=5'b11000, rfill=1, rempty=0.
REQ-032 SHALL verify underflow: rempty=1, rinc=1 one cycle -> rptr unchanged, runderflow=1 next edge and held; rerr_clr=1 with rinc=0 -> runderflow=0; rerr_clr=1 with rinc=1 while empty -> runderflow stays 1.
REQ-033 SHALL verify full occupancy: rbin=0, rq2_wptr=gray(16)=5'b11000 -> rfill=16, rempty=0, raempty=0; 16 consecutive reads -> rempty=1 exactly on 16th edge, rptr=5'b11000.
REQ-034 SHALL verify reset mid-drain: rfill=5, rinc=1, rrst=1 for one edge -> all outputs at reset values that edge, no read counted.
